fft_input_loader: RTL
=====================

// Module: fft_input_loader
// PURPOSE
//   Upstream stage of fft_top. Accepts a stream of 32-bit complex samples over
//   valid/ready, packs 4 samples per 128-bit word, and writes N/4 words into the
//   shared 256x128 sample SRAM in natural order.
//   Then raises o_fft_working to start fft_top, holds it until i_fft_done, and
//   pulses o_load_done. One frame per i_load_start.
// PARAMETERS
//   SAMPLE_W  32   complex sample width: {re[15:0], im[15:0]}, re in [31:16]
//   LANES     4    samples per SRAM word (word width = SAMPLE_W*LANES = 128)
//   ADDR_W    8    SRAM word address width (256 words)
//   CFG_W     3    point-config width; N = 2^(cfg+3), so 8..1024 points
// PORTS
//   clk             in   1    clock
//   rstn            in   1    synchronous active-low reset
//   i_load_start    in   1    1-cycle request to load a frame; sampled only in IDLE
//   i_point_config  in   3    frame size select; latched on accepted i_load_start
//   s_valid         in   1    sample valid
//   s_ready         out  1    loader can accept a sample
//   s_data          in   32   complex sample
//   o_we            out  1    SRAM write strobe, one word per cycle
//   o_waddr         out  8    SRAM word address
//   o_wdata         out  128  packed word; lane k in bits [32k+31:32k]
//   o_fft_working   out  1    drives fft_top i_working
//   o_point_config  out  3    latched cfg, drives fft_top i_point_config
//   i_fft_done      in   1    fft_top o_fft_done
//   o_busy          out  1    high in every state except IDLE
//   o_load_done     out  1    1-cycle pulse when the frame completes
// BEHAVIOUR
//   Reset (rstn=0 at posedge): state=IDLE. s_ready, o_we, o_fft_working,
//     o_busy and o_load_done are 0. o_waddr=0, o_wdata=0, o_point_config=0.
//     Sample counter and lane buffer are cleared. Reset mid-frame abandons
//     the frame; no further writes are issued.
//   FSM states: IDLE, LOAD, FLUSH, RUN, DONE. All outputs are registered.
//   IDLE: i_load_start=1 latches cfg, clears cnt, goes to LOAD.
//     i_load_start is ignored in every other state.
//   LOAD: s_ready=1. A sample is accepted on a posedge where s_valid&s_ready.
//     Accepted sample cnt goes to lane cnt[1:0].
//     When lane 3 is accepted, the next cycle shows o_we=1,
//     o_waddr=cnt[9:2], and o_wdata={s_data, lane2, lane1, lane0}.
//     o_we is 1 for exactly one cycle per word; 1-cycle write latency.
//     On accepting sample N-1, go to FLUSH; s_ready drops that same edge.
//     s_valid gaps pause cnt and add no writes.
//   FLUSH: one cycle. o_we is high for the last word. Go to RUN.
//   RUN: o_fft_working=1, starting the cycle after the last o_we. Stay in RUN
//     until i_fft_done=1, then go to DONE; o_fft_working falls on that edge.
//   DONE: o_load_done=1 for one cycle, then back to IDLE.
//   i_fft_done is ignored outside RUN. s_valid in IDLE, FLUSH, RUN or DONE is
//     not accepted (s_ready=0).
//   Counter is 10 bits. Addresses go 0..N/4-1 and never wrap: cfg=7 uses
//     words 0..255 exactly.
//   o_point_config holds the latched value from the accepted start until the
//     next accepted start.
// TESTING
//   1 cfg=0, s_valid held, s_data=k for k=0..7 -> o_we twice: addr0=
//     0x00000003_00000002_00000001_00000000 and addr1=..07_06_05_04;
//     o_fft_working rises the cycle after the 2nd o_we.
//   2 cfg=1, s_valid toggled 1,0,1,0 over 16 samples -> exactly 4 writes, addr
//     0..3, correct packing; no write on gap cycles; s_ready stays 1 in LOAD.
//   3 cfg=7, 1024 samples -> 256 writes, addr 0..255 in order; s_ready=0 from
//     the edge sample 1023 is accepted.
//   4 i_load_start during LOAD/RUN, and i_fft_done during LOAD -> no effect.
//     i_fft_done in RUN -> o_fft_working 0 next cycle, one o_load_done pulse,
//     o_busy=0 after it.
//   5 rstn=0 after 6 samples of cfg=2 -> all outputs at reset values. A new
//     start with cfg=0 then writes addr 0 with fresh samples, not stale lanes.
//   6 Closed loop with fft_top and an SRAM model -> fft_top writes match the
//     golden mem_writes file for cfg=0 and cfg=7.

Source files
------------

// File: rtl/fft_input_loader.sv
// fft_input_loader: upstream stage of fft_top. It collects a frame of complex
// samples over valid/ready and packs LANES samples per SRAM word. It writes
// N/LANES words in natural order, then hands the frame to fft_top and waits
// for fft_top to finish.
module fft_input_loader #(
    parameter int unsigned SAMPLE_W = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CFG_W    = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_load_start,
    input  logic [CFG_W-1:0]          i_point_config,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_W-1:0]       s_data,
    output logic                      o_we,
    output logic [ADDR_W-1:0]         o_waddr,
    output logic [SAMPLE_W*LANES-1:0] o_wdata,
    output logic                      o_fft_working,
    output logic [CFG_W-1:0]          o_point_config,
    input  logic                      i_fft_done,
    output logic                      o_busy,
    output logic                      o_load_done
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = ADDR_W + LANE_W;
    localparam int unsigned WORD_W = SAMPLE_W * LANES;

    // Smallest frame is 8 points; N = 8 << cfg.
    localparam logic [CNT_W:0] MIN_PTS = (CNT_W + 1)'(8);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] lane_q [LANES-1];

    logic [CNT_W:0]      n_pts;
    logic [CNT_W-1:0]    last_idx;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   word;

    // Frame length and index of the final sample, from the latched config.
    // For the largest frame n_pts[CNT_W-1:0] is 0, so last_idx wraps to all ones.
    always_comb begin
        n_pts    = MIN_PTS << o_point_config;
        last_idx = n_pts[CNT_W-1:0] - CNT_W'(1);
        lane     = cnt[LANE_W-1:0];
    end

    // Word assembled from the buffered lanes plus the sample arriving in the top lane.
    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < LANES - 1; k++) begin
            word[k*SAMPLE_W +: SAMPLE_W] = lane_q[k];
        end
        word[(LANES-1)*SAMPLE_W +: SAMPLE_W] = s_data;
    end

    // Loader FSM: all outputs, counter and lane buffer are registered here.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            s_ready        <= 1'b0;
            o_we           <= 1'b0;
            o_waddr        <= '0;
            o_wdata        <= '0;
            o_fft_working  <= 1'b0;
            o_point_config <= '0;
            o_busy         <= 1'b0;
            o_load_done    <= 1'b0;
            for (int unsigned k = 0; k < LANES - 1; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            o_we        <= 1'b0;
            o_load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_load_start) begin
                        o_point_config <= i_point_config;
                        cnt            <= '0;
                        s_ready        <= 1'b1;
                        o_busy         <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        if (lane == LANE_W'(LANES - 1)) begin
                            o_we    <= 1'b1;
                            o_waddr <= cnt[CNT_W-1:LANE_W];
                            o_wdata <= word;
                        end else begin
                            lane_q[lane] <= s_data;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == last_idx) begin
                            s_ready <= 1'b0;
                            state   <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    o_fft_working <= 1'b1;
                    state         <= RUN;
                end
                RUN: begin
                    if (i_fft_done) begin
                        o_fft_working <= 1'b0;
                        o_load_done   <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    s_ready       <= 1'b0;
                    o_fft_working <= 1'b0;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
